io_out_port: RTL and testbench

IO_OUT_PORT -- requirements
Module: io_out_port

---
 rtl/io_out_pkg.sv | 14 +
 rtl/out_fifo.sv | 72 +++++++
 rtl/io_out_port.sv | 82 ++++++++
 tb/tb_io_out_port.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/io_out_pkg.sv
// rtl/io_out_pkg.sv - shared defaults and channel-state type for the output port
package io_out_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_NCH   = 2;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } ch_state_e;

endpackage

// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - single-channel output FIFO with registered head and valid/ready drain
module out_fifo
  import io_out_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic             accept,
  output logic             drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  ch_state_e        state;
  logic             pop;

  always_comb begin
    state = PARTIAL;
    if (count == '0)
      state = EMPTY;
    else if (count == CW'(DEPTH))
      state = FULL;
  end

  // A pop on the same edge frees the slot, so a full channel still accepts
  assign pop    = (state != EMPTY) && ready;
  assign accept = push && ((state != FULL) || pop);
  assign drop   = push && (state == FULL) && !pop;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)
        count <= count + 1'b1;
      else if (pop && !accept)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= din;
  end

  // Storage is not reset; masking by occupancy keeps dout at zero while empty
  assign valid = (state != EMPTY);
  assign full  = (state == FULL);
  assign empty = (state == EMPTY);
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/io_out_port.sv
// rtl/io_out_port.sv - NCH-channel output port: write demux, out_view, overflow flags
// OUTPORT_OVF_EN enables sticky per-channel overflow flags; otherwise overflow is tied low.
module io_out_port
  import io_out_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     bus_in,
  input  logic                 out_rd,
  input  logic [SELW-1:0]      ch_sel,
  input  logic [NCH-1:0]       dev_ready,
  output logic [NCH*WIDTH-1:0] dev_data,
  output logic [NCH-1:0]       dev_valid,
  output logic [NCH-1:0]       full,
  output logic [NCH-1:0]       empty,
  output logic [WIDTH-1:0]     out_view,
  input  logic                 ovf_clr,
  output logic [NCH-1:0]       overflow
);

  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  logic           sel_ok;
  logic [NCH-1:0] push;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] drop;

  assign sel_ok = ({1'b0, ch_sel} < NCH_W);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign push[g] = out_rd && sel_ok && (ch_sel == SELW'(g));

    out_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push[g]),
      .din   (bus_in),
      .ready (dev_ready[g]),
      .dout  (dev_data[g*WIDTH +: WIDTH]),
      .valid (dev_valid[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .accept(accept[g]),
      .drop  (drop[g])
    );
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      out_view <= '0;
    else if (|accept)
      out_view <= bus_in;
  end

`ifdef OUTPORT_OVF_EN
  logic [NCH-1:0] ovf_q;

  // A drop on the clearing edge must survive, so set is applied after clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)
      ovf_q <= '0;
    else
      ovf_q <= (ovf_q & ~{NCH{ovf_clr}}) | drop;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf = ovf_clr ^ (^drop);
  assign overflow   = '0;
`endif

endmodule

// File: tb/tb_io_out_port.sv
// tb/tb_io_out_port.sv - directed scoreboard bench for io_out_port
module tb_io_out_port;

`ifdef OUTPORT_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] bus_in;
  logic        out_rd;
  logic [0:0]  ch_sel;
  logic [1:0]  dev_ready;
  logic [63:0] dev_data;
  logic [1:0]  dev_valid;
  logic [1:0]  full;
  logic [1:0]  empty;
  logic [31:0] out_view;
  logic        ovf_clr;
  logic [1:0]  overflow;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  io_out_port dut (
    .clk      (clk),
    .clr      (clr),
    .bus_in   (bus_in),
    .out_rd   (out_rd),
    .ch_sel   (ch_sel),
    .dev_ready(dev_ready),
    .dev_data (dev_data),
    .dev_valid(dev_valid),
    .full     (full),
    .empty    (empty),
    .out_view (out_view),
    .ovf_clr  (ovf_clr),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic [31:0] d, input bit acc);
    out_rd = 1'b1;
    ch_sel = ch[0];
    bus_in = d;
    if (acc) begin
      if (ch == 0) q0.push_back(d);
      else         q1.push_back(d);
    end
    step();
    out_rd = 1'b0;
  endtask

  // Monitor: a transfer happens at the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    if (clr) begin
      if (dev_valid[0] && dev_ready[0]) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ch0_unexpected: got 0x%08h expected nothing", dev_data[31:0]);
        end else begin
          chk("ch0_pop", dev_data[31:0], q0.pop_front());
        end
      end
      if (dev_valid[1] && dev_ready[1]) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ch1_unexpected: got 0x%08h expected nothing", dev_data[63:32]);
        end else begin
          chk("ch1_pop", dev_data[63:32], q1.pop_front());
        end
      end
    end
  end

  initial begin
    clr       = 1'b0;
    bus_in    = '0;
    out_rd    = 1'b0;
    ch_sel    = '0;
    dev_ready = '0;
    ovf_clr   = 1'b0;
    #2;
    chk("rst_valid", 32'(dev_valid), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_ovf", 32'(overflow), 32'h0);
    chk("rst_view", out_view, 32'h0);
    chk("rst_data_lo", dev_data[31:0], 32'h0);
    chk("rst_data_hi", dev_data[63:32], 32'h0);
    step();
    clr = 1'b1;
    step();

    // single push, latency one edge
    push(0, 32'h0000_00AB, 1'b1);
    chk("ab_valid", 32'(dev_valid[0]), 32'h1);
    chk("ab_data", dev_data[31:0], 32'hAB);
    chk("ab_view", out_view, 32'hAB);
    chk("ab_empty", 32'(empty[0]), 32'h0);
    dev_ready[0] = 1'b1;
    step();
    dev_ready[0] = 1'b0;
    chk("ab_drained", 32'(empty[0]), 32'h1);

    // fill ch1, drop the fifth push
    for (int i = 1; i <= 4; i++) push(1, 32'(i), 1'b1);
    chk("fill_full1", 32'(full[1]), 32'h1);
    chk("fill_full0", 32'(full[0]), 32'h0);
    push(1, 32'h5, 1'b0);
    chk("drop_view", out_view, 32'h4);
    chk("drop_ovf", 32'(overflow[1]), 32'(OVF_ON));
    chk("drop_head", dev_data[63:32], 32'h1);
    chk("drop_full", 32'(full[1]), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);
    dev_ready[1] = 1'b1;
    repeat (5) step();
    dev_ready[1] = 1'b0;
    chk("fill_drained", 32'(empty[1]), 32'h1);

    // push and pop on the same edge while full
    for (int i = 0; i < 4; i++) push(0, 32'h10 + 32'(i), 1'b1);
    dev_ready[0] = 1'b1;
    push(0, 32'h55, 1'b1);
    dev_ready[0] = 1'b0;
    chk("pp_full", 32'(full[0]), 32'h1);
    chk("pp_head", dev_data[31:0], 32'h11);
    chk("pp_ovf", 32'(overflow[0]), 32'h0);
    dev_ready[0] = 1'b1;
    repeat (5) step();
    dev_ready[0] = 1'b0;
    chk("pp_drained", 32'(empty[0]), 32'h1);

    // no crosstalk between channels
    dev_ready = 2'b11;
    push(0, 32'h11, 1'b1);
    push(1, 32'h22, 1'b1);
    repeat (3) step();
    dev_ready = 2'b00;
    chk("xt_empty", 32'(empty), 32'h3);

    // ten values through ch0 across pointer wrap with toggling ready
    for (int i = 0; i < 20; i++) begin
      dev_ready[0] = i[0];
      if (i[0] == 1'b0) push(0, 32'hA0 + 32'(i / 2), 1'b1);
      else              step();
    end
    dev_ready[0] = 1'b1;
    repeat (3) step();
    dev_ready[0] = 1'b0;
    chk("wrap_empty", 32'(empty[0]), 32'h1);

    // asynchronous reset with ch1 holding three entries
    for (int i = 0; i < 3; i++) push(1, 32'h31 + 32'(i), 1'b1);
    chk("pre_rst_valid", 32'(dev_valid[1]), 32'h1);
    #3;
    clr = 1'b0;
    q1.delete();
    #1;
    chk("arst_valid", 32'(dev_valid), 32'h0);
    chk("arst_empty", 32'(empty), 32'h3);
    chk("arst_full", 32'(full), 32'h0);
    chk("arst_view", out_view, 32'h0);
    chk("arst_data_hi", dev_data[63:32], 32'h0);
    step();
    clr = 1'b1;
    step();
    chk("post_rst_valid", 32'(dev_valid[1]), 32'h0);
    push(1, 32'h77, 1'b1);
    chk("post_rst_push_valid", 32'(dev_valid[1]), 32'h1);
    chk("post_rst_push_data", dev_data[63:32], 32'h77);
    dev_ready[1] = 1'b1;
    repeat (2) step();
    dev_ready[1] = 1'b0;
    chk("post_rst_empty", 32'(empty[1]), 32'h1);

    chk("q0_left", 32'(q0.size()), 32'h0);
    chk("q1_left", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
